// File: rtl/cordic_angle_entry_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : cordic_ui_pkg                                            |
// | Description : Shared types and constants for the CORDIC angle-entry    |
// |               front panel: FSM state encoding, step-size table,        |
// |               step-selector width and step helper functions.           |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package cordic_ui_pkg;

   // Width of the step selector (values 0..2 are used).
   localparam int STEP_IDX_W = 2;
   // Width of one step-table entry (largest step is 90).
   localparam int STEP_W     = 7;

   typedef enum logic [1:0] {
      EDIT      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2
   } state_e;

   // Step sizes in degrees, indexed by step_idx.
   localparam logic [STEP_W-1:0] STEP_TABLE [0:2] = '{7'd1, 7'd10, 7'd90};

   // Step size for a selector value; the unused code 3 falls back to 1 degree.
   function automatic logic [STEP_W-1:0] step_of(input logic [STEP_IDX_W-1:0] idx);
      logic [STEP_W-1:0] s;
      case (idx)
         2'd1:    s = STEP_TABLE[1];
         2'd2:    s = STEP_TABLE[2];
         default: s = STEP_TABLE[0];
      endcase
      return s;
   endfunction

   // Selector rotation 0 -> 1 -> 2 -> 0.
   function automatic logic [STEP_IDX_W-1:0] next_step_idx(input logic [STEP_IDX_W-1:0] idx);
      return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage : cordic_ui_pkg
`default_nettype wire

// File: rtl/cordic_angle_entry_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface   : cordic_angle_entry_if                                    |
// | Description : Bundle between the button debouncers / CORDIC core and   |
// |               the angle-entry block.                                   |
// |   press_up/down/sel/go : debounced button levels                       |
// |   start_ready, done    : handshake inputs from the CORDIC core         |
// |   angle_deg, step_idx  : current target angle and step selector       |
// |   start, busy, err     : request, activity and timeout indications    |
// |   modport slave  : the angle-entry block                               |
// |   modport master : the surrounding environment                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface cordic_angle_entry_if
   import cordic_ui_pkg::*;
#(
   parameter int ANGLE_W = 9
) ();

   logic                  press_up;
   logic                  press_down;
   logic                  press_sel;
   logic                  press_go;
   logic                  start_ready;
   logic                  done;
   logic [ANGLE_W-1:0]    angle_deg;
   logic [STEP_IDX_W-1:0] step_idx;
   logic                  start;
   logic                  busy;
   logic                  err;

   modport slave (
      input  press_up, press_down, press_sel, press_go, start_ready, done,
      output angle_deg, step_idx, start, busy, err
   );

   modport master (
      output press_up, press_down, press_sel, press_go, start_ready, done,
      input  angle_deg, step_idx, start, busy, err
   );

endinterface : cordic_angle_entry_if
`default_nettype wire

// File: rtl/cordic_angle_entry_rise_detect.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : rise_detect                                              |
// | Description : Rising-edge detector for one debounced button level.     |
// |   clk, rst : clock, asynchronous active-high reset                     |
// |   level_i  : debounced level                                           |
// |   event_o  : single-cycle pulse on a 0->1 transition of level_i        |
// |   The history flop resets to 1 so a button already held when reset    |
// |   releases does not count as a press.                                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic level_i,
   output logic event_o
);

   logic prev_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level_i;
      end
   end

   assign event_o = level_i & ~prev_q;

endmodule : rise_detect
`default_nettype wire

// File: rtl/cordic_angle_entry.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : cordic_angle_entry                                       |
// | Description : Front-panel angle entry for the CORDIC core. up/down     |
// |               add/subtract the selected step modulo ANGLE_MAX+1, sel   |
// |               rotates the step (1/10/90), go issues the angle to the   |
// |               core over start/start_ready and waits for done.          |
// |   clk, rst : clock, asynchronous active-high reset                     |
// |   ui       : cordic_angle_entry_if.slave (buttons, handshake, outputs) |
// |   Optional : define CORDIC_TIMEOUT_EN to enable the done watchdog      |
// |              (TIMEOUT_CYC cycles in WAIT_DONE -> err pulse, EDIT).     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module cordic_angle_entry
   import cordic_ui_pkg::*;
#(
   parameter int ANGLE_W     = 9,
   parameter int ANGLE_MAX   = 359,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   cordic_angle_entry_if.slave ui
);

   // One extra bit so angle+step never overflows before the modulo fold.
   typedef logic [ANGLE_W:0] ext_t;
   localparam ext_t MODULUS = ext_t'(ANGLE_MAX + 1);
   localparam ext_t LIMIT   = ext_t'(ANGLE_MAX);

   state_e                state_q, state_d;
   logic [ANGLE_W-1:0]    angle_q, angle_d;
   logic [STEP_IDX_W-1:0] step_idx_q, step_idx_d;
   logic                  err_q, err_d;

   // ---------------------------------------------------------------- edges
   logic [3:0] levels;
   logic [3:0] events;
   logic       ev_up, ev_down, ev_sel, ev_go;

   assign levels = {ui.press_go, ui.press_sel, ui.press_down, ui.press_up};

   for (genvar g = 0; g < 4; g++) begin : g_rise
      rise_detect u_rise (
         .clk     (clk),
         .rst     (rst),
         .level_i (levels[g]),
         .event_o (events[g])
      );
   end

   assign ev_up   = events[0];
   assign ev_down = events[1];
   assign ev_sel  = events[2];
   assign ev_go   = events[3];

   // ----------------------------------------------------------- arithmetic
   ext_t               step_ext, angle_ext, sum_ext;
   logic [ANGLE_W-1:0] angle_up, angle_down;

   always_comb begin
      step_ext   = ext_t'(step_of(step_idx_q));
      angle_ext  = {1'b0, angle_q};
      sum_ext    = angle_ext + step_ext;
      angle_up   = ANGLE_W'((sum_ext > LIMIT) ? sum_ext - MODULUS : sum_ext);
      // Borrow case adds the modulus first so the subtraction never goes negative.
      angle_down = ANGLE_W'((angle_ext < step_ext) ? angle_ext + MODULUS - step_ext
                                                   : angle_ext - step_ext);
   end

   // -------------------------------------------------------------- watchdog
   logic timeout;

`ifdef CORDIC_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Held at zero outside WAIT_DONE, so it starts from zero on every entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == WAIT_DONE) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (state_q == WAIT_DONE) && (cnt_q == CNT_LAST);
`else
   assign timeout = 1'b0;
`endif

   // ------------------------------------------------------------------ FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EDIT;
         angle_q    <= '0;
         step_idx_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         angle_q    <= angle_d;
         step_idx_q <= step_idx_d;
         err_q      <= err_d;
      end
   end

   // Events only act in EDIT; elsewhere they are dropped, not queued.
   always_comb begin
      state_d    = state_q;
      angle_d    = angle_q;
      step_idx_d = step_idx_q;
      err_d      = 1'b0;
      case (state_q)
         EDIT: begin
            if (ev_go) begin
               state_d = ISSUE;
            end else if (ev_sel) begin
               step_idx_d = next_step_idx(step_idx_q);
            end else if (ev_up) begin
               angle_d = angle_up;
            end else if (ev_down) begin
               angle_d = angle_down;
            end
         end
         ISSUE: begin
            if (ui.start_ready) begin
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            // done has priority over a coincident watchdog expiry.
            if (ui.done) begin
               state_d = EDIT;
            end else if (timeout) begin
               state_d = EDIT;
               err_d   = 1'b1;
            end
         end
         default: begin
            state_d = EDIT;
         end
      endcase
   end

   assign ui.angle_deg = angle_q;
   assign ui.step_idx  = step_idx_q;
   assign ui.start     = (state_q == ISSUE);
   assign ui.busy      = (state_q != EDIT);
   assign ui.err       = err_q;

endmodule : cordic_angle_entry
`default_nettype wire

// File: tb/tb_cordic_angle_entry.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_cordic_angle_entry                                    |
// | Description : Self-checking bench for cordic_angle_entry. A degree-    |
// |               level model (modulo arithmetic on integers, step table   |
// |               array) predicts angle and step; handshake and reset      |
// |               behaviour is checked against fixed expectations.         |
// |               Honours CORDIC_TIMEOUT_EN for the watchdog scenario.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_cordic_angle_entry;

   localparam int ANGLE_W     = 9;
   localparam int ANGLE_MAX   = 359;
   localparam int TIMEOUT_CYC = 16;

   localparam logic [3:0] M_UP   = 4'b0001;
   localparam logic [3:0] M_DOWN = 4'b0010;
   localparam logic [3:0] M_SEL  = 4'b0100;
   localparam logic [3:0] M_GO   = 4'b1000;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cordic_angle_entry_if #(.ANGLE_W(ANGLE_W)) ui ();

   cordic_angle_entry #(
      .ANGLE_W     (ANGLE_W),
      .ANGLE_MAX   (ANGLE_MAX),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .ui  (ui)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state (degrees and selector as plain integers).
   int m_angle;
   int m_idx;
   int step_tbl [3] = '{1, 10, 90};

   task automatic model_reset();
      m_angle = 0;
      m_idx   = 0;
   endtask

   // Effect of one press (or simultaneous presses) while idle.
   task automatic model_press(input logic [3:0] mask);
      if (mask[3]) begin
         // go leaves angle and step untouched
      end else if (mask[2]) begin
         m_idx = (m_idx + 1) % 3;
      end else if (mask[0]) begin
         m_angle = (m_angle + step_tbl[m_idx]) % (ANGLE_MAX + 1);
      end else if (mask[1]) begin
         m_angle = (m_angle - step_tbl[m_idx] + ANGLE_MAX + 1) % (ANGLE_MAX + 1);
      end
   endtask

   task automatic drive(input logic [3:0] mask);
      ui.press_up   = mask[0];
      ui.press_down = mask[1];
      ui.press_sel  = mask[2];
      ui.press_go   = mask[3];
   endtask

   task automatic press(input logic [3:0] mask, input int hold, input int gap);
      @(negedge clk);
      drive(mask);
      repeat (hold) @(negedge clk);
      drive(4'b0000);
      repeat (gap) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive(4'b0000);
      ui.start_ready = 1'b0;
      ui.done        = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   // Issue go and complete the start handshake; returns at the first
   // WAIT_DONE sample point.
   task automatic enter_wait_done(output bit ok);
      ok = 1'b0;
      @(negedge clk);
      drive(M_GO);
      @(negedge clk);
      drive(4'b0000);
      for (int k = 0; k < 10; k++) begin
         if (ui.start) begin
            ui.start_ready = 1'b1;
            @(negedge clk);
            ui.start_ready = 1'b0;
            ok = !ui.start && ui.busy;
            break;
         end
         @(negedge clk);
      end
   endtask

   // ------------------------------------------------------------ scenarios
   task automatic test_reset();
      @(negedge clk);
      n_cmp++; if (ui.angle_deg !== 9'd0) begin n_fail++; $display("FAIL reset_angle: got %0d want 0", ui.angle_deg); end
      n_cmp++; if (ui.step_idx !== 2'd0)  begin n_fail++; $display("FAIL reset_step: got %0d want 0", ui.step_idx); end
      n_cmp++; if (ui.start !== 1'b0)     begin n_fail++; $display("FAIL reset_start: got %b want 0", ui.start); end
      n_cmp++; if (ui.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", ui.busy); end
      n_cmp++; if (ui.err !== 1'b0)       begin n_fail++; $display("FAIL reset_err: got %b want 0", ui.err); end
      rst = 1'b0;
      @(negedge clk);
      model_reset();
   endtask

   task automatic test_up_presses();
      bit start_seen = 1'b0;
      do_reset();
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            ui.press_up = (c < 20);
            if (ui.start) start_seen = 1'b1;
         end
         model_press(M_UP);
      end
      n_cmp++; if (ui.angle_deg !== 9'd3) begin n_fail++; $display("FAIL up_x3_angle: got %0d want 3", ui.angle_deg); end
      n_cmp++; if (start_seen !== 1'b0)   begin n_fail++; $display("FAIL up_x3_start: start seen high, want never"); end
   endtask

   task automatic test_wrap();
      do_reset();
      press(M_SEL, 2, 2);  model_press(M_SEL);   // step 10
      press(M_DOWN, 2, 2); model_press(M_DOWN);  // 350
      press(M_SEL, 2, 2);  model_press(M_SEL);
      press(M_SEL, 2, 2);  model_press(M_SEL);   // step 1
      for (int i = 0; i < 5; i++) begin
         press(M_UP, 2, 2); model_press(M_UP);
      end
      n_cmp++; if (ui.angle_deg !== 9'(m_angle)) begin n_fail++; $display("FAIL wrap_setup: got %0d want %0d", ui.angle_deg, m_angle); end
      press(M_SEL, 2, 2);  model_press(M_SEL);   // step 10
      press(M_UP, 2, 2);   model_press(M_UP);
      n_cmp++; if (ui.angle_deg !== 9'd5) begin n_fail++; $display("FAIL wrap_up: got %0d want 5", ui.angle_deg); end
      press(M_SEL, 2, 2);  model_press(M_SEL);   // step 90
      press(M_DOWN, 2, 2); model_press(M_DOWN);
      n_cmp++; if (ui.angle_deg !== 9'd275) begin n_fail++; $display("FAIL wrap_down: got %0d want 275", ui.angle_deg); end
      n_cmp++; if (ui.step_idx !== 2'd2)    begin n_fail++; $display("FAIL wrap_step: got %0d want 2", ui.step_idx); end
   endtask

   task automatic test_sel_priority();
      do_reset();
      press(M_UP, 1, 2); model_press(M_UP);
      for (int i = 1; i <= 3; i++) begin
         press(M_SEL, 3, 2); model_press(M_SEL);
         n_cmp++; if (ui.step_idx !== 2'(i % 3)) begin n_fail++; $display("FAIL sel_cycle_%0d: got %0d want %0d", i, ui.step_idx, i % 3); end
      end
      press(M_UP | M_DOWN | M_SEL, 3, 2); model_press(M_UP | M_DOWN | M_SEL);
      n_cmp++; if (ui.step_idx !== 2'(m_idx))    begin n_fail++; $display("FAIL prio_step: got %0d want %0d", ui.step_idx, m_idx); end
      n_cmp++; if (ui.angle_deg !== 9'(m_angle)) begin n_fail++; $display("FAIL prio_angle: got %0d want %0d", ui.angle_deg, m_angle); end
   endtask

   task automatic test_random_edit();
      logic [3:0] mask;
      for (int i = 0; i < 40; i++) begin
         mask = 4'($urandom_range(1, 7));
         press(mask, $urandom_range(1, 4), $urandom_range(1, 3));
         model_press(mask);
         n_cmp++;
         if (ui.angle_deg !== 9'(m_angle) || ui.step_idx !== 2'(m_idx)) begin
            n_fail++;
            $display("FAIL rand_%0d mask=%b: got angle %0d step %0d want angle %0d step %0d",
                     i, mask, ui.angle_deg, ui.step_idx, m_angle, m_idx);
         end
      end
   endtask

   task automatic test_handshake();
      int  start_cnt = 0;
      bit  stable    = 1'b1;
      int  a0        = m_angle;
      @(negedge clk);
      drive(M_GO);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 3) drive(4'b0000);
         if (ui.start) begin
            start_cnt++;
            if (ui.angle_deg !== 9'(a0) || ui.busy !== 1'b1) stable = 1'b0;
         end
         if (k == 6) ui.start_ready = 1'b1;
         if (k == 7) ui.start_ready = 1'b0;
      end
      n_cmp++; if (start_cnt != 6)  begin n_fail++; $display("FAIL hs_start_len: got %0d cycles want 6", start_cnt); end
      n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL hs_stable: angle/busy changed while start high, want stable"); end
      n_cmp++; if (ui.busy !== 1'b1) begin n_fail++; $display("FAIL hs_wait_busy: got %b want 1", ui.busy); end
      for (int i = 0; i < 3; i++) press(M_UP, 2, 2);
      n_cmp++; if (ui.angle_deg !== 9'(a0)) begin n_fail++; $display("FAIL hs_up_ignored: got %0d want %0d", ui.angle_deg, a0); end
      @(negedge clk); ui.done = 1'b1;
      @(negedge clk); ui.done = 1'b0;
      n_cmp++; if (ui.busy !== 1'b0 || ui.start !== 1'b0) begin n_fail++; $display("FAIL hs_done: got busy %b start %b want 0 0", ui.busy, ui.start); end
      @(negedge clk); ui.done = 1'b1;
      @(negedge clk); ui.done = 1'b0;
      n_cmp++; if (ui.busy !== 1'b0) begin n_fail++; $display("FAIL hs_stray_done: got busy %b want 0", ui.busy); end
      press(M_UP, 2, 2); model_press(M_UP);
      n_cmp++; if (ui.angle_deg !== 9'(m_angle)) begin n_fail++; $display("FAIL hs_after_up: got %0d want %0d", ui.angle_deg, m_angle); end
   endtask

   task automatic test_reset_cases();
      bit ok;
      press(M_UP, 2, 2);
      @(negedge clk);
      ui.press_up = 1'b1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      n_cmp++; if (ui.angle_deg !== 9'd0) begin n_fail++; $display("FAIL held_through_reset: got %0d want 0", ui.angle_deg); end
      ui.press_up = 1'b0;
      repeat (2) @(negedge clk);
      press(M_UP, 2, 2); press(M_UP, 2, 2);
      model_press(M_UP); model_press(M_UP);
      n_cmp++; if (ui.angle_deg !== 9'(m_angle)) begin n_fail++; $display("FAIL post_reset_up: got %0d want %0d", ui.angle_deg, m_angle); end
      enter_wait_done(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rst_enter_wait: got no WAIT_DONE want WAIT_DONE"); end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (ui.start !== 1'b0 || ui.busy !== 1'b0 || ui.angle_deg !== 9'd0) begin
         n_fail++;
         $display("FAIL rst_in_wait: got start %b busy %b angle %0d want 0 0 0", ui.start, ui.busy, ui.angle_deg);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   task automatic test_timeout();
      bit ok;
      enter_wait_done(ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL to_enter_wait: got no WAIT_DONE want WAIT_DONE"); end
`ifdef CORDIC_TIMEOUT_EN
      begin
         int   busy_cnt = 1;
         logic err_at_exit = 1'b0;
         bit   exited = 1'b0;
         for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ui.busy) begin
               busy_cnt++;
               if (ui.err) err_at_exit = 1'b1;
            end else begin
               err_at_exit = ui.err;
               exited = 1'b1;
               break;
            end
         end
         n_cmp++; if (!exited)          begin n_fail++; $display("FAIL to_exit: got busy stuck want EDIT"); end
         n_cmp++; if (busy_cnt != TIMEOUT_CYC) begin n_fail++; $display("FAIL to_len: got %0d cycles want %0d", busy_cnt, TIMEOUT_CYC); end
         n_cmp++; if (err_at_exit !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", err_at_exit); end
         @(negedge clk);
         n_cmp++; if (ui.err !== 1'b0) begin n_fail++; $display("FAIL to_err_pulse: got %b want 0", ui.err); end
      end
`else
      repeat (40) @(negedge clk);
      n_cmp++; if (ui.busy !== 1'b1) begin n_fail++; $display("FAIL no_to_busy: got %b want 1", ui.busy); end
      n_cmp++; if (ui.err !== 1'b0)  begin n_fail++; $display("FAIL no_to_err: got %b want 0", ui.err); end
      ui.done = 1'b1;
      @(negedge clk);
      ui.done = 1'b0;
      n_cmp++; if (ui.busy !== 1'b0) begin n_fail++; $display("FAIL no_to_done: got %b want 0", ui.busy); end
`endif
   endtask

   // ------------------------------------------------------------- sequence
   initial begin
      rst            = 1'b1;
      ui.start_ready = 1'b0;
      ui.done        = 1'b0;
      drive(4'b0000);
      model_reset();
      test_reset();
      test_up_presses();
      test_wrap();
      test_sel_priority();
      test_random_edit();
      test_handshake();
      test_reset_cases();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "time limit");
   end

endmodule : tb_cordic_angle_entry
`default_nettype wire
